// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcodes, FSM encodings and small helpers for the two-port ALU arbiter.
package alu_share_arbiter_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD         = 3'b000;
  localparam alu_ctrl_t ALU_SUB         = 3'b001;
  localparam alu_ctrl_t ALU_AND         = 3'b010;
  localparam alu_ctrl_t ALU_OR          = 3'b011;
  localparam alu_ctrl_t ALU_XOR         = 3'b100;
  localparam alu_ctrl_t ALU_SLT         = 3'b101;
  localparam alu_ctrl_t ALU_ILLEGAL_MIN = 3'b110;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  function automatic logic is_illegal(input alu_ctrl_t ctrl);
    return ctrl >= ALU_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's view of the shared ALU: request channel plus response channel.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  alu_ctrl_t   req_ctrl;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_err;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; illegal opcodes produce zero.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctrl_t   ctrl_i,
  output logic [31:0] y_o
);
  logic [31:0] diff;
  logic        ovf;

  assign diff = a_i - b_i;
  // signed overflow of a-b: operand signs differ and result sign differs from a
  assign ovf  = (a_i[31] ^ b_i[31]) & (diff[31] ^ a_i[31]);

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = diff;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {31'b0, diff[31] ^ ovf};
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one ALU; one op in flight, result held until its owner takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   port0,
  alu_share_arbiter_if.slave   port1
);
  logic [0:0]  state_q, state_d;
  logic        owner_q, last_grant_q;
  logic [31:0] result_q;
  logic        zero_q, err_q;

  logic        owner_rdy, can_accept, pick1, accept;
  logic [31:0] op_a, op_b, alu_y;
  alu_ctrl_t   op_ctrl;
  logic        op_err;

  assign owner_rdy  = owner_q ? port1.resp_ready : port0.resp_ready;
  assign can_accept = ~reset & ((state_q == S_IDLE) | owner_rdy);

  // port 1 wins when alone, or on contention when round-robin says it is its turn
  assign pick1  = port1.req_valid & (~port0.req_valid | (RR_EN & ~last_grant_q));
  assign accept = can_accept & (port0.req_valid | port1.req_valid);

  assign port0.req_ready = can_accept & port0.req_valid & ~pick1;
  assign port1.req_ready = can_accept & pick1;

  assign op_a    = pick1 ? port1.req_a    : port0.req_a;
  assign op_b    = pick1 ? port1.req_b    : port0.req_b;
  assign op_ctrl = pick1 ? port1.req_ctrl : port0.req_ctrl;
  assign op_err  = is_illegal(op_ctrl);

  alu_share_arbiter_alu u_alu (
    .a_i    (op_a),
    .b_i    (op_b),
    .ctrl_i (op_ctrl),
    .y_o    (alu_y)
  );

  always_comb begin
    state_d = state_q;
    if (accept)                                   state_d = S_HOLD;
    else if ((state_q == S_HOLD) && owner_rdy)    state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= pick1;
        last_grant_q <= pick1;
        result_q     <= op_err ? 32'd0 : alu_y;
        zero_q       <= op_err | (alu_y == 32'd0);
        err_q        <= op_err;
      end
    end
  end

  assign port0.resp_valid  = (state_q == S_HOLD) & ~owner_q;
  assign port1.resp_valid  = (state_q == S_HOLD) &  owner_q;
  assign port0.resp_result = result_q;
  assign port1.resp_result = result_q;
  assign port0.resp_zero   = zero_q;
  assign port1.resp_zero   = zero_q;
  assign port0.resp_err    = err_q;
  assign port1.resp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: DUT "a" is round-robin, DUT "b" fixed-priority; both see identical stimulus.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if a0 ();
  alu_share_arbiter_if a1 ();
  alu_share_arbiter_if b0 ();
  alu_share_arbiter_if b1 ();

  alu_share_arbiter #(.RR_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .port0(a0), .port1(a1));
  alu_share_arbiter #(.RR_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .port0(b0), .port1(b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] c);
    if (p == 0) begin
      a0.req_valid = v; a0.req_a = a; a0.req_b = b; a0.req_ctrl = c;
      b0.req_valid = v; b0.req_a = a; b0.req_b = b; b0.req_ctrl = c;
    end else begin
      a1.req_valid = v; a1.req_a = a; a1.req_b = b; a1.req_ctrl = c;
      b1.req_valid = v; b1.req_a = a; b1.req_b = b; b1.req_ctrl = c;
    end
  endtask

  task automatic set_rr(input int p, input logic r);
    if (p == 0) begin a0.resp_ready = r; b0.resp_ready = r; end
    else        begin a1.resp_ready = r; b1.resp_ready = r; end
  endtask

  function automatic logic rdy_a(input int p);
    return (p == 0) ? a0.req_ready : a1.req_ready;
  endfunction

  function automatic logic rv_a(input int p);
    return (p == 0) ? a0.resp_valid : a1.resp_valid;
  endfunction

  // single op on one port with resp_ready high; checks accept, 1-cycle latency, data, release
  task automatic op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] c, input logic [31:0] er, input logic ez, input logic ee);
    @(negedge clk);
    drv(p, 1'b1, a, b, c);
    #1 chk({tag, ".ready"}, 32'(rdy_a(p)), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(rv_a(p)), 32'd1);
    chk({tag, ".other_valid"}, 32'(rv_a(1 - p)), 32'd0);
    chk({tag, ".result"}, a0.resp_result, er);
    chk({tag, ".zero"}, 32'(a0.resp_zero), 32'(ez));
    chk({tag, ".err"}, 32'(a0.resp_err), 32'(ee));
    @(negedge clk);
    drv(p, 1'b0, 32'd0, 32'd0, ALU_ADD);
    @(posedge clk); #1;
    chk({tag, ".released"}, 32'(rv_a(p)), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    set_rr(0, 1'b1);
    set_rr(1, 1'b1);
    do_reset();

    #1;
    chk("rst.valid0", 32'(a0.resp_valid), 32'd0);
    chk("rst.valid1", 32'(a1.resp_valid), 32'd0);
    chk("rst.ready0", 32'(a0.req_ready), 32'd0);
    chk("rst.result", a0.resp_result, 32'd0);
    chk("rst.zero", 32'(a0.resp_zero), 32'd0);
    chk("rst.err", 32'(a0.resp_err), 32'd0);

    op("add5_7", 0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0);
    op("sub9_9", 1, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1, 1'b0);
    op("slt_m1_1", 1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1, 1'b0, 1'b0);
    op("slt_min_1", 1, 32'h8000_0000, 32'd1, ALU_SLT, 32'd1, 1'b0, 1'b0);
    op("slt_max_m1", 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, ALU_SLT, 32'd0, 1'b1, 1'b0);
    op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b0);
    op("xor", 1, 32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_XOR, 32'hFF00_0FF0, 1'b0, 1'b0);
    op("or", 0, 32'h0000_1200, 32'h0000_0034, ALU_OR, 32'h0000_1234, 1'b0, 1'b0);
    op("ill110", 0, 32'd3, 32'd4, 3'b110, 32'd0, 1'b1, 1'b1);
    op("and_clr", 0, 32'd7, 32'd3, ALU_AND, 32'd3, 1'b0, 1'b0);
    op("ill111", 1, 32'd1, 32'd1, 3'b111, 32'd0, 1'b1, 1'b1);

    // contention from reset: a alternates 0,1,0,1; b always port 0
    do_reset();
    drv(0, 1'b1, 32'd10, 32'd0, ALU_ADD);
    drv(1, 1'b1, 32'd20, 32'd0, ALU_ADD);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d.a_rdy0", k), 32'(a0.req_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d.a_rdy1", k), 32'(a1.req_ready), 32'((k % 2) == 1));
      chk($sformatf("rr%0d.b_rdy0", k), 32'(b0.req_ready), 32'd1);
      chk($sformatf("rr%0d.b_rdy1", k), 32'(b1.req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("rr%0d.a_valid", k), 32'(rv_a(k % 2)), 32'd1);
      chk($sformatf("rr%0d.a_result", k), a0.resp_result, ((k % 2) == 0) ? 32'd10 : 32'd20);
      chk($sformatf("rr%0d.b_valid0", k), 32'(b0.resp_valid), 32'd1);
      chk($sformatf("rr%0d.b_result", k), b0.resp_result, 32'd10);
      @(negedge clk);
    end
    drv(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    @(posedge clk); #1;
    chk("rr.drain", 32'(a0.resp_valid | a1.resp_valid), 32'd0);

    // hold: owner 0 stalls, port 1 must wait, then is accepted in the release cycle
    @(negedge clk);
    set_rr(0, 1'b0);
    drv(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    drv(1, 1'b1, 32'd4, 32'd4, ALU_ADD);
    #1 chk("hold.rdy0", 32'(a0.req_ready), 32'd1);
    chk("hold.rdy1_first", 32'(a1.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("hold%0d.rdy1", k), 32'(a1.req_ready), 32'd0);
      chk($sformatf("hold%0d.valid0", k), 32'(a0.resp_valid), 32'd1);
      chk($sformatf("hold%0d.result", k), a0.resp_result, 32'd2);
      chk($sformatf("hold%0d.valid1", k), 32'(a1.resp_valid), 32'd0);
      @(negedge clk);
    end
    set_rr(0, 1'b1);
    #1 chk("hold.release_rdy1", 32'(a1.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("hold.p1_valid", 32'(a1.resp_valid), 32'd1);
    chk("hold.p1_result", a1.resp_result, 32'd8);
    chk("hold.p0_valid", 32'(a0.resp_valid), 32'd0);
    @(negedge clk);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    @(posedge clk);

    // reset while holding a result
    @(negedge clk);
    set_rr(0, 1'b0);
    drv(0, 1'b1, 32'd3, 32'd4, ALU_ADD);
    @(posedge clk); #1;
    chk("abort.valid0", 32'(a0.resp_valid), 32'd1);
    chk("abort.result", a0.resp_result, 32'd7);
    @(negedge clk);
    drv(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.rst_valid0", 32'(a0.resp_valid), 32'd0);
    chk("abort.rst_result", a0.resp_result, 32'd0);
    chk("abort.rst_ready", 32'({a0.req_ready, a1.req_ready}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_rr(0, 1'b1);
    @(posedge clk); #1;
    chk("abort.no_resp", 32'(a0.resp_valid | a1.resp_valid), 32'd0);
    @(negedge clk);
    drv(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    drv(1, 1'b1, 32'd5, 32'd6, ALU_ADD);
    #1 chk("abort.first_rdy0", 32'(a0.req_ready), 32'd1);
    chk("abort.first_rdy1", 32'(a1.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort.first_result", a0.resp_result, 32'd3);
    @(negedge clk);
    drv(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    @(posedge clk); @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
